// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
// Holds the controller state enum, fetch bundle and default constants.
package ifetch_pkg;

  typedef enum logic {
    S_FETCH,
    S_LOAD
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          FIFO_DEPTH       = 2;

endpackage

// File: rtl/ifetch_fifo2.sv
// Two-entry {pc,inst} output buffer with push, pop and flush.
// Ports: push/din in, pop, flush; dout (head), nxt (second), count/full/empty.
module ifetch_fifo2
  import ifetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  fetch_t     din,
  output fetch_t     dout,
  output fetch_t     nxt,
  output logic [1:0] count,
  output logic       full,
  output logic       empty
);

  fetch_t e0;
  fetch_t e1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e0    <= '0;
      e1    <= '0;
      count <= 2'd0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count == 2'd0) e0 <= din;
          else               e1 <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          e0    <= e1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            e0 <= din;
          end else begin
            e0 <= e1;
            e1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout  = e0;
  assign nxt   = e1;
  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller sharing one inst_ram port with a loader.
// Ports: ram_* (RAM port), ld_* (loader), redirect*, out_* (valid/ready).
module ifetch_ctrl
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = ifetch_pkg::FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ram_ena,
  output logic [3:0]  ram_wea,
  output logic [9:0]  ram_addra,
  output logic [31:0] ram_dina,
  input  logic [31:0] ram_douta,
  input  logic        ld_req,
  input  logic [9:0]  ld_addr,
  input  logic [31:0] ld_data,
  output logic        ld_gnt,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst
);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] rd_pc_q;
  logic        infl_q;

  fetch_t      head, nxt;
  logic [1:0]  count;
  logic        full, empty;
  logic        pop, push, flush, issue;
  logic [2:0]  occ, lim;
  logic [31:0] rewind_pc;

  assign pop   = out_valid & out_ready;
  assign flush = redirect | ld_req;
  assign push  = infl_q & ~flush & (~full | pop);

  // Occupancy after this cycle's pop, counting the read already in flight.
  assign occ   = {1'b0, count} + {2'b0, infl_q};
  assign lim   = 3'(FIFO_DEPTH) + {2'b0, pop};
  assign issue = ~rst & (state_q == S_FETCH) & ~ld_req & ~redirect
               & (occ < lim);

  // Oldest PC not yet handed to the consumer, after any pop this cycle.
  always_comb begin
    rewind_pc = pc_q;
    if (count > {1'b0, pop}) begin
      rewind_pc = pop ? nxt.pc : head.pc;
    end else if (infl_q) begin
      rewind_pc = rd_pc_q;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      S_FETCH: if (ld_req)  state_d = S_LOAD;
      S_LOAD:  if (!ld_req) state_d = S_FETCH;
      default: state_d = S_FETCH;
    endcase
    if (redirect) begin
      pc_d = redirect_pc & ~32'h3;
    end else if (ld_req && state_q == S_FETCH) begin
      pc_d = rewind_pc;
    end else if (issue) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_comb begin
    ram_ena   = 1'b0;
    ram_wea   = 4'b0000;
    ram_addra = 10'd0;
    ram_dina  = 32'd0;
    ld_gnt    = 1'b0;
    unique case (1'b1)
      (ld_req & ~rst): begin
        ld_gnt    = 1'b1;
        ram_ena   = 1'b1;
        ram_wea   = 4'b1111;
        ram_addra = ld_addr;
        ram_dina  = ld_data;
      end
      issue: begin
        ram_ena   = 1'b1;
        ram_addra = pc_q[11:2];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      rd_pc_q <= 32'd0;
      infl_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      infl_q  <= issue;
      if (issue) rd_pc_q <= pc_q;
    end
  end

  ifetch_fifo2 u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   ('{pc: rd_pc_q, inst: ram_douta}),
    .dout  (head),
    .nxt   (nxt),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign out_valid = ~empty;
  assign out_pc    = head.pc;
  assign out_inst  = head.inst;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Scoreboard bench for ifetch_ctrl with a behavioural inst_ram.
// Directed phases: stream, stall, redirect, load, wrap, mid-stream reset.
module tb_ifetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ram_ena;
  logic [3:0]  ram_wea;
  logic [9:0]  ram_addra;
  logic [31:0] ram_dina;
  logic [31:0] ram_douta = 32'd0;
  logic        ld_req = 1'b0;
  logic [9:0]  ld_addr = 10'd0;
  logic [31:0] ld_data = 32'd0;
  logic        ld_gnt;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_inst;

  int tests = 0;
  int fails = 0;

  logic [63:0] expq[$];
  logic [31:0] mem [1024];

  ifetch_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .ram_ena     (ram_ena),
    .ram_wea     (ram_wea),
    .ram_addra   (ram_addra),
    .ram_dina    (ram_dina),
    .ram_douta   (ram_douta),
    .ld_req      (ld_req),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .ld_gnt      (ld_gnt),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_inst    (out_inst)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = i;
  end

  always @(posedge clk) begin
    if (ram_ena) begin
      if (ram_wea != 4'b0000) begin
        for (int b = 0; b < 4; b++)
          if (ram_wea[b]) mem[ram_addra][8*b +: 8] <= ram_dina[8*b +: 8];
      end else begin
        ram_douta <= mem[ram_addra];
      end
    end
  end

  // Monitor: every transfer must match the oldest expectation.
  always @(negedge clk) begin
    logic [63:0] e;
    if (!rst && out_valid && out_ready) begin
      tests++;
      if (expq.size() == 0) begin
        fails++;
        $display("FAIL xfer_extra: got pc=%h inst=%h, required none",
                 out_pc, out_inst);
      end else begin
        e = expq.pop_front();
        if ({out_pc, out_inst} !== e) begin
          fails++;
          $display("FAIL xfer: got pc=%h inst=%h, required pc=%h inst=%h",
                   out_pc, out_inst, e[63:32], e[31:0]);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic expect_xfer(input logic [31:0] pc, input logic [31:0] inst);
    expq.push_back({pc, inst});
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    neg();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_pc",    out_pc,             32'd0);
    chk("rst_inst",  out_inst,           32'd0);
    chk("rst_ena",   {31'd0, ram_ena},   32'd0);
    chk("rst_wea",   {28'd0, ram_wea},   32'd0);
    chk("rst_addra", {22'd0, ram_addra}, 32'd0);
    chk("rst_dina",  ram_dina,           32'd0);
    chk("rst_gnt",   {31'd0, ld_gnt},    32'd0);

    // Stream from RESET_PC
    for (int i = 0; i < 8; i++) expect_xfer(32'(4 * i), 32'(i));
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    neg();
    chk("first_rd_ena",  {31'd0, ram_ena},   32'd1);
    chk("first_rd_addr", {22'd0, ram_addra}, 32'd0);
    chk("first_rd_wea",  {28'd0, ram_wea},   32'd0);
    tick();
    neg();
    chk("lat_cyc1_valid", {31'd0, out_valid}, 32'd0);
    tick();
    neg();
    chk("lat_cyc2_valid", {31'd0, out_valid}, 32'd1);
    repeat (8) tick();
    out_ready = 1'b0;
    tick();
    neg();
    chk("stall_pc",    out_pc,             32'h20);
    chk("stall_valid", {31'd0, out_valid}, 32'd1);

    // Redirect with two buffered entries
    tick();
    redirect = 1'b1;
    redirect_pc = 32'h0000_0103;
    tick();
    redirect = 1'b0;
    out_ready = 1'b1;
    expect_xfer(32'h100, 32'h40);
    expect_xfer(32'h104, 32'h41);
    expect_xfer(32'h108, 32'h42);
    neg();
    chk("redir_c1_valid", {31'd0, out_valid}, 32'd0);
    tick();
    neg();
    chk("redir_c2_valid", {31'd0, out_valid}, 32'd0);
    tick();
    neg();
    chk("redir_c3_valid", {31'd0, out_valid}, 32'd1);
    chk("redir_c3_pc",    out_pc,             32'h100);
    repeat (3) tick();
    out_ready = 1'b0;

    // Loader preempts fetch; pc rewinds to the in-flight read at 8
    repeat (2) tick();
    redirect = 1'b1;
    redirect_pc = 32'h0;
    tick();
    redirect = 1'b0;
    out_ready = 1'b1;
    expect_xfer(32'h0,  32'h0);
    expect_xfer(32'h4,  32'h1);
    expect_xfer(32'h8,  32'hDEAD_0002);
    expect_xfer(32'hC,  32'h3);
    expect_xfer(32'h10, 32'h4);
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      ld_req  = 1'b1;
      ld_addr = 10'(i);
      ld_data = 32'hDEAD_0000 + 32'(i);
      neg();
      chk("ld_gnt",   {31'd0, ld_gnt},    32'd1);
      chk("ld_addra", {22'd0, ram_addra}, 32'(i));
      if (i == 0) begin
        chk("ld_wea",  {28'd0, ram_wea}, 32'hF);
        chk("ld_dina", ram_dina,         32'hDEAD_0000);
      end
      tick();
    end
    ld_req = 1'b0;
    neg();
    chk("ld_gnt_off", {31'd0, ld_gnt}, 32'd0);
    tick();
    neg();
    chk("rewind_ena",  {31'd0, ram_ena},   32'd1);
    chk("rewind_addr", {22'd0, ram_addra}, 32'd2);
    chk("rewind_wea",  {28'd0, ram_wea},   32'd0);
    repeat (5) tick();
    out_ready = 1'b0;

    // Re-fetch the freshly loaded words
    repeat (2) tick();
    redirect = 1'b1;
    redirect_pc = 32'h0;
    tick();
    redirect = 1'b0;
    out_ready = 1'b1;
    expect_xfer(32'h0, 32'hDEAD_0000);
    expect_xfer(32'h4, 32'hDEAD_0001);
    expect_xfer(32'h8, 32'hDEAD_0002);
    repeat (5) tick();
    out_ready = 1'b0;

    // PC wraparound
    repeat (2) tick();
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    out_ready = 1'b1;
    expect_xfer(32'hFFFF_FFFC, 32'h3FF);
    expect_xfer(32'h0,         32'hDEAD_0000);
    expect_xfer(32'h4,         32'hDEAD_0001);
    neg();
    chk("wrap_addr_hi", {22'd0, ram_addra}, 32'h3FF);
    tick();
    neg();
    chk("wrap_addr_lo", {22'd0, ram_addra}, 32'h0);
    repeat (4) tick();
    out_ready = 1'b0;

    // Mid-stream reset, then a 5-cycle stall on the first entry
    tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_pc",    out_pc,             32'd0);
    chk("mid_rst_inst",  out_inst,           32'd0);
    chk("mid_rst_ena",   {31'd0, ram_ena},   32'd0);
    tick();
    rst = 1'b0;
    expect_xfer(32'h0, 32'hDEAD_0000);
    expect_xfer(32'h4, 32'hDEAD_0001);
    expect_xfer(32'h8, 32'hDEAD_0002);
    neg();
    chk("restart_ena",  {31'd0, ram_ena},   32'd1);
    chk("restart_addr", {22'd0, ram_addra}, 32'd0);
    repeat (2) tick();
    neg();
    chk("restart_valid", {31'd0, out_valid}, 32'd1);
    chk("restart_pc",    out_pc,             32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      neg();
      chk("hold_pc",  out_pc,           32'd0);
      chk("hold_ena", {31'd0, ram_ena}, 32'd0);
    end
    tick();
    out_ready = 1'b1;
    repeat (3) tick();
    out_ready = 1'b0;

    repeat (3) tick();
    chk("sb_drained", 32'(expq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
